alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised successor of the pipeline EX-stage ALU: registered single-cycle integer ops plus a multi-cycle multiply/divide unit with architectural HI/LO registers.
- Adds a valid/ready handshake, a signed-overflow flag and a pipeline flush input.
- Sits in the EX stage. The hazard unit stalls ID/EX while in_ready is low.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and at least 8.
- SHAMT_W, 5, shift-amount bits; must equal clog2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  equals !busy; an op is accepted when in_valid && in_ready.
- alu_op  in  5  operation code, with `ALU_* codes from def.v.
- a  in  WIDTH  operand A, signed; carries the shift amount for shift ops.
- b  in  WIDTH  operand B, signed.
- out_valid  out  1  c, zero and ovf hold a result for one cycle.
- c  out  WIDTH  registered result.
- zero  out  1  equals (c == 0), combinational from the c register.
- ovf  out  1  signed overflow on ADD/SUB, registered with c.
- busy  out  1  iterative MULT/DIV in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset values: out_valid=0, c=0 (so zero=1), ovf=0, busy=0, hi=0, lo=0.
- Reset mid-operation aborts the MD engine.
- Priority at each edge: rst, then flush, then accept.
- Flush: out_valid=0 next cycle, busy=0, and any in-progress MD op is aborted with hi/lo unchanged.
- Single-cycle ops: accepted at edge N; c, ovf and out_valid=1 are visible after edge N. Latency is 1.
- When no op is accepted, out_valid=0 next cycle and c holds its value.
- NOP: c=0.
- ADD/SUB: c=a±b modulo 2^WIDTH. ovf=1 when both operands (b negated for SUB) share a sign and the result sign differs; otherwise ovf=0. ovf is 0 for every other op.
- ADDU/SUBU: wrap, ovf=0.
- AND/OR/XOR/NOR: bitwise.
- SLT: signed less-than, result 1/0. SLTU: unsigned less-than, result 1/0.
- SLL/SRL/SRA: shift b by a[SHAMT_W-1:0]; SRA is arithmetic.
- LUI: c = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- BEQ/BNE/BLEZ/BGEZ/BGTZ/BLTZ: 1/0 from signed compares.
- MFHI/MFLO: c = hi or lo. MTHI/MTLO: hi or lo = a, out_valid=0.
- Unknown opcode: c=a.
- MULT/MULTU/DIV/DIVU accepted at edge N:
  - Operands are latched. busy=1 from N+1 for exactly WIDTH cycles; in_ready=0 meanwhile.
  - At edge N+WIDTH, hi/lo are written and busy falls. out_valid stays 0.
  - The next op, including MFHI, is accepted at the edge where busy=0 is sampled, so it sees the new hi/lo.
- MULT/MULTU: {hi,lo} = full 2·WIDTH product, signed or unsigned.
- DIV/DIVU: lo=quotient, hi=remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Division by zero: lo = all ones, hi = a.
- Signed overflow, -2^(WIDTH-1) / -1: lo = -2^(WIDTH-1), hi = 0.
- An op offered while busy is not accepted; the source holds it.

Optional Feature:
- Macro: ALU_MD_FAST_MUL_EN.
- Defined: MULT/MULTU use a registered array multiplier. hi/lo are written at edge N, busy never rises and in_ready stays 1. DIV/DIVU remain iterative.
- Undefined: MULT/MULTU iterate for WIDTH cycles as above.

Decomposition:
- def.v (shared):
  - All `ALU_* opcodes, including new ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_MTHI and ALU_MTLO, with unique 5-bit values.
  - An `ALU_IS_MD(op) helper macro.
- Sub-module alu_md_iter:
  - Shift-add multiplier and restoring divider sharing one counter, one accumulator and sign-fixup logic.
  - Interface: start, signed_op, is_div, a, b, abort, busy, done, hi_out, lo_out.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 → next cycle: c=0x80000000, ovf=1, out_valid=1. ADDU with the same operands → ovf=0.
- SUB a=5, b=5 → c=0, zero=1. SRA a=4, b=0x80000000 → c=0xF8000000. LUI b=0x1234 → c=0x12340000.
- MULT a=-3, b=7 → busy high for 32 cycles, in_ready=0 throughout. Then hi=0xFFFFFFFF, lo=0xFFFFFFEB, and MFLO issued back-to-back returns 0xFFFFFFEB.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=9, b=0 → lo=0xFFFFFFFF, hi=9. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- MTHI a=0xAA, then DIVU, then flush at cycle 10 of busy → busy=0 next cycle and MFHI returns 0xAA. Assert rst during a MULT → hi=lo=0, busy=0.
- With ALU_MD_FAST_MUL_EN defined: MULTU a=0xFFFFFFFF, b=2 → busy never rises; hi=1 and lo=0xFFFFFFFE after one edge.

Source files
------------

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared ALU opcodes and MD helpers; optional macro ALU_MD_FAST_MUL_EN selects single-cycle MULT/MULTU
`ifndef ALU_NOP
`define ALU_NOP   5'd0
`define ALU_ADD   5'd1
`define ALU_ADDU  5'd2
`define ALU_SUB   5'd3
`define ALU_SUBU  5'd4
`define ALU_AND   5'd5
`define ALU_OR    5'd6
`define ALU_XOR   5'd7
`define ALU_NOR   5'd8
`define ALU_SLT   5'd9
`define ALU_SLTU  5'd10
`define ALU_SLL   5'd11
`define ALU_SRL   5'd12
`define ALU_SRA   5'd13
`define ALU_LUI   5'd14
`define ALU_BEQ   5'd15
`define ALU_BNE   5'd16
`define ALU_BLEZ  5'd17
`define ALU_BGEZ  5'd18
`define ALU_BGTZ  5'd19
`define ALU_BLTZ  5'd20
`define ALU_MULT  5'd21
`define ALU_MULTU 5'd22
`define ALU_DIV   5'd23
`define ALU_DIVU  5'd24
`define ALU_MFHI  5'd25
`define ALU_MFLO  5'd26
`define ALU_MTHI  5'd27
`define ALU_MTLO  5'd28
`define ALU_IS_MD(op) ((op) == `ALU_MULT || (op) == `ALU_MULTU || (op) == `ALU_DIV || (op) == `ALU_DIVU)
`endif
package alu_md_pkg;
  localparam logic [4:0] OP_NOP   = `ALU_NOP;
  localparam logic [4:0] OP_ADD   = `ALU_ADD;
  localparam logic [4:0] OP_ADDU  = `ALU_ADDU;
  localparam logic [4:0] OP_SUB   = `ALU_SUB;
  localparam logic [4:0] OP_SUBU  = `ALU_SUBU;
  localparam logic [4:0] OP_AND   = `ALU_AND;
  localparam logic [4:0] OP_OR    = `ALU_OR;
  localparam logic [4:0] OP_XOR   = `ALU_XOR;
  localparam logic [4:0] OP_NOR   = `ALU_NOR;
  localparam logic [4:0] OP_SLT   = `ALU_SLT;
  localparam logic [4:0] OP_SLTU  = `ALU_SLTU;
  localparam logic [4:0] OP_SLL   = `ALU_SLL;
  localparam logic [4:0] OP_SRL   = `ALU_SRL;
  localparam logic [4:0] OP_SRA   = `ALU_SRA;
  localparam logic [4:0] OP_LUI   = `ALU_LUI;
  localparam logic [4:0] OP_BEQ   = `ALU_BEQ;
  localparam logic [4:0] OP_BNE   = `ALU_BNE;
  localparam logic [4:0] OP_BLEZ  = `ALU_BLEZ;
  localparam logic [4:0] OP_BGEZ  = `ALU_BGEZ;
  localparam logic [4:0] OP_BGTZ  = `ALU_BGTZ;
  localparam logic [4:0] OP_BLTZ  = `ALU_BLTZ;
  localparam logic [4:0] OP_MULT  = `ALU_MULT;
  localparam logic [4:0] OP_MULTU = `ALU_MULTU;
  localparam logic [4:0] OP_DIV   = `ALU_DIV;
  localparam logic [4:0] OP_DIVU  = `ALU_DIVU;
  localparam logic [4:0] OP_MFHI  = `ALU_MFHI;
  localparam logic [4:0] OP_MFLO  = `ALU_MFLO;
  localparam logic [4:0] OP_MTHI  = `ALU_MTHI;
  localparam logic [4:0] OP_MTLO  = `ALU_MTLO;
  function automatic logic is_md(input logic [4:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: WIDTH-cycle shift-add multiplier / restoring divider working on operand magnitudes
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, acc_n, q_n, am, bm;
  logic div, neg_q, neg_r, sa, sb;
  logic [WIDTH:0] sum, rem, diff;
  logic [2*WIDTH-1:0] prod;
  assign sa = signed_op && a[WIDTH-1];
  assign sb = signed_op && b[WIDTH-1];
  assign am = sa ? -a : a;
  assign bm = sb ? -b : b;
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign rem = {acc, q[WIDTH-1]};
  assign diff = rem - {1'b0, m};
  assign acc_n = div ? (diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
  assign q_n = div ? {q[WIDTH-2:0], !diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  assign prod = neg_q ? -{acc_n, q_n} : {acc_n, q_n};
  assign done = busy && cnt == CW'(WIDTH - 1);
  // A zero divisor leaves the dividend magnitude in acc, so the sign fixup already yields hi = a
  assign hi_out = div ? (neg_r ? -acc_n : acc_n) : prod[2*WIDTH-1:WIDTH];
  assign lo_out = div ? (m == '0 ? '1 : neg_q ? -q_n : q_n) : prod[WIDTH-1:0];
  always_ff @(posedge clk)
    if (rst || abort) busy <= 1'b0;
    else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      q     <= am;
      m     <= bm;
      div   <= is_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end else if (busy) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
endmodule

// File: rtl/alu_md.sv
// alu_md: registered EX-stage ALU with HI/LO multiply/divide unit; ALU_MD_FAST_MUL_EN makes MULT/MULTU single-cycle
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic accept, single, iter_op, it_done, res_ovf;
  logic [WIDTH-1:0] sum, dif, res, it_hi, it_lo;
  assign in_ready = !busy;
  assign accept = in_valid && in_ready;
  assign single = !is_md(alu_op) && alu_op != OP_MTHI && alu_op != OP_MTLO;
  assign zero = c == '0;
  assign sum = a + b;
  assign dif = a - b;
`ifdef ALU_MD_FAST_MUL_EN
  logic fmul;
  logic [2*WIDTH-1:0] ae, be, prod;
  assign fmul = alu_op == OP_MULT || alu_op == OP_MULTU;
  assign ae = alu_op == OP_MULT ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign be = alu_op == OP_MULT ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod = ae * be;
  assign iter_op = alu_op == OP_DIV || alu_op == OP_DIVU;
`else
  assign iter_op = is_md(alu_op);
`endif
  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .rst(rst),
    .start(accept && iter_op && !flush),
    .signed_op(alu_op == OP_MULT || alu_op == OP_DIV),
    .is_div(alu_op == OP_DIV || alu_op == OP_DIVU),
    .abort(flush),
    .a(a),
    .b(b),
    .busy(busy),
    .done(it_done),
    .hi_out(it_hi),
    .lo_out(it_lo)
  );
  always_comb begin
    res_ovf = alu_op == OP_ADD ? a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1] :
              alu_op == OP_SUB ? a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1] : 1'b0;
    case (alu_op)
      OP_NOP:           res = '0;
      OP_ADD, OP_ADDU:  res = sum;
      OP_SUB, OP_SUBU:  res = dif;
      OP_AND:           res = a & b;
      OP_OR:            res = a | b;
      OP_XOR:           res = a ^ b;
      OP_NOR:           res = ~(a | b);
      OP_SLT:           res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU:          res = WIDTH'(a < b);
      OP_SLL:           res = b << a[SHAMT_W-1:0];
      OP_SRL:           res = b >> a[SHAMT_W-1:0];
      OP_SRA:           res = $signed(b) >>> a[SHAMT_W-1:0];
      OP_LUI:           res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_BEQ:           res = WIDTH'(a == b);
      OP_BNE:           res = WIDTH'(a != b);
      OP_BLEZ:          res = WIDTH'(a[WIDTH-1] || a == '0);
      OP_BGEZ:          res = WIDTH'(!a[WIDTH-1]);
      OP_BGTZ:          res = WIDTH'(!a[WIDTH-1] && a != '0);
      OP_BLTZ:          res = WIDTH'(a[WIDTH-1]);
      OP_MFHI:          res = hi;
      OP_MFLO:          res = lo;
      default:          res = a;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) out_valid <= 1'b0;
    else begin
      out_valid <= accept && single;
      if (accept && single) begin
        c   <= res;
        ovf <= res_ovf;
      end
      if (accept && alu_op == OP_MTHI) hi <= a;
      if (accept && alu_op == OP_MTLO) lo <= a;
      if (it_done) begin
        hi <= it_hi;
        lo <= it_lo;
      end
`ifdef ALU_MD_FAST_MUL_EN
      if (accept && fmul) {hi, lo} <= prod;
`endif
    end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed scoreboard bench for alu_md (also covers the ALU_MD_FAST_MUL_EN build)
module tb_alu_md;
  import alu_md_pkg::*;
  localparam int W = 32;
`ifdef ALU_MD_FAST_MUL_EN
  localparam logic [4:0] RST_OP = OP_DIV;
`else
  localparam logic [4:0] RST_OP = OP_MULT;
`endif
  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, zero, ovf, busy;
  logic [4:0] alu_op;
  logic [W-1:0] a, b, c, hi, lo;
  typedef struct {
    logic [W-1:0] c;
    logic         ovf;
  } exp_t;
  exp_t sb[$];
  int total = 0, passed = 0;
  int n;
  alu_md #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .c(c), .zero(zero),
    .ovf(ovf), .busy(busy), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic drive(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
  endtask
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ec, input logic eo);
    exp_t e;
    drive(op, x, y);
    e.c = ec;
    e.ovf = eo;
    sb.push_back(e);
  endtask
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask
  task automatic md(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int cnt);
    drive(op, x, y);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_while_busy", in_ready, 0);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  always @(negedge clk)
    if (!rst && out_valid) begin
      exp_t e;
      if (sb.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("c", c, e.c);
        chk("ovf", ovf, e.ovf);
        chk("zero", zero, e.c == '0);
      end
    end
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = OP_NOP; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;
    issue(OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
    issue(OP_ADDU, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0);
    issue(OP_SUB,  32'h5,        32'h5,        32'h0,        1'b0);
    issue(OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1);
    issue(OP_SUBU, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0);
    issue(OP_SRA,  32'h4,        32'h80000000, 32'hF8000000, 1'b0);
    issue(OP_SRL,  32'h4,        32'h80000000, 32'h08000000, 1'b0);
    issue(OP_SLL,  32'h24,       32'h1,        32'h10,       1'b0);
    issue(OP_LUI,  32'h0,        32'h1234,     32'h12340000, 1'b0);
    issue(OP_AND,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0);
    issue(OP_OR,   32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0);
    issue(OP_XOR,  32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0);
    issue(OP_NOR,  32'hF0F0,     32'hFF00,     32'hFFFF000F, 1'b0);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
    issue(OP_BEQ,  32'h3,        32'h3,        32'h1,        1'b0);
    issue(OP_BNE,  32'h3,        32'h3,        32'h0,        1'b0);
    issue(OP_BLEZ, 32'h0,        32'h0,        32'h1,        1'b0);
    issue(OP_BGTZ, 32'h0,        32'h0,        32'h0,        1'b0);
    issue(OP_BLTZ, 32'hFFFFFFFB, 32'h0,        32'h1,        1'b0);
    issue(OP_BGEZ, 32'hFFFFFFFB, 32'h0,        32'h0,        1'b0);
    issue(OP_NOP,  32'h1,        32'h2,        32'h0,        1'b0);
    issue(5'd31,   32'hDEAD,     32'h2,        32'hDEAD,     1'b0);
    idle(2);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_c_hold", c, 32'hDEAD);
`ifdef ALU_MD_FAST_MUL_EN
    drive(OP_MULTU, 32'hFFFFFFFF, 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fast_busy", busy, 0);
    chk("fast_in_ready", in_ready, 1);
    chk("fast_hi", hi, 32'h1);
    chk("fast_lo", lo, 32'hFFFFFFFE);
    chk("fast_out_valid", out_valid, 0);
    drive(OP_MULT, 32'hFFFFFFFD, 32'h7);
    issue(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    idle(1);
`else
    drive(OP_MULT, 32'hFFFFFFFD, 32'h7);
    drive(OP_MFLO, 32'h0, 32'h0);
    chk("mult_in_ready", in_ready, 0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk("mult_out_valid_low", out_valid, 0);
      @(negedge clk);
    end
    chk("mult_busy_cycles", n, 32);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    begin
      exp_t e;
      e.c = 32'hFFFFFFEB;
      e.ovf = 1'b0;
      sb.push_back(e);
    end
    idle(1);
`endif
    md(OP_DIV, 32'hFFFFFFF9, 32'h2, n);
    chk("div_cycles", n, 32);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    md(OP_DIV, 32'h9, 32'h0, n);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'h9);
    md(OP_DIVU, 32'd100, 32'd7, n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);
    drive(OP_MTHI, 32'hAA, 32'h0);
    drive(OP_DIVU, 32'd100, 32'd7);
    idle(1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_hi", hi, 32'hAA);
    chk("flush_lo", lo, 32'h80000000);
    issue(OP_MFHI, 32'h0, 32'h0, 32'hAA, 1'b0);
    idle(2);
    drive(RST_OP, 32'hFFFFFFFD, 32'h7);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_md_busy", busy, 0);
    chk("rst_md_hi", hi, 0);
    chk("rst_md_lo", lo, 0);
    chk("rst_md_c", c, 0);
    idle(3);
    chk("rst_md_stays_idle", busy, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
